// File: rtl/lenet_ctrl_pkg.sv
// Shared control definitions for the LeNet-5 layer sequencers.
// Holds the sequencer state encoding, the per-layer depth constants and a
// small helper used when sizing counters.
package lenet_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    DRAIN     = 3'd2,
    BIAS      = 3'd3,
    LATCH     = 3'd4,
    HANDOFF   = 3'd5,
    WAIT_NEXT = 3'd6
  } fc_state_t;

  localparam int FC1_IFM_DEPTH       = 120;
  localparam int FC2_IFM_DEPTH       = 84;
  localparam int DEFAULT_MAC_LATENCY = 3;

  // Larger of two widths; the shared counter must hold both the last read
  // index and the last drain index.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fc_seq_counter.sv
// Loadable up-counter with a terminal-count flag.
// Cleared to zero on reset or on clear; increments on inc but never moves past
// the terminal value, so the value it drives as an address stays in range.
module fc_seq_counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  assign at_terminal = (count == terminal);

  // Clear has priority over increment; increment stops at the terminal value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !at_terminal) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Control unit for one fully-connected layer of the LeNet-5 pipeline.
// Streams IFM_DEPTH input reads with matching weight addresses, waits for the
// MAC pipeline to drain, applies bias, latches outputs and hands off to the
// next layer. All outputs are registered, driven from the state being entered.
// Optional build macro FC_SEQ_PERF_EN adds a perf_cycles busy-cycle counter.
module fc_layer_sequencer
  import lenet_ctrl_pkg::*;
#(
  parameter int IFM_DEPTH   = FC1_IFM_DEPTH,
  parameter int ADDR_W      = $clog2(IFM_DEPTH),
  parameter int MAC_LATENCY = DEFAULT_MAC_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_from_previous,
  input  logic              end_from_next,
  output logic              enable_read_current,
  output logic              wm_enable_read,
  output logic              wm_addr_sel,
  output logic [ADDR_W-1:0] wm_address_read_current,
  output logic              bias_sel,
  output logic              fc_output_ready,
  output logic              enable_write_next,
  output logic              end_to_previous,
  output logic              start_to_next,
  output logic              busy
`ifdef FC_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int LAT_W = $clog2(MAC_LATENCY + 1);
  localparam int CNT_W = max_int(ADDR_W, LAT_W);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(IFM_DEPTH - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MAC_LATENCY - 1);

  fc_state_t        state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_plus_one;
  logic [CNT_W-1:0] cnt_terminal;
  logic             at_terminal;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             accept_start;

  assign accept_start   = (state == IDLE) && start_from_previous;
  assign count_plus_one = count + CNT_W'(1);

  // Counter control: cleared when a run starts and when reading hands over to
  // draining; it counts read addresses first and then drain cycles.
  always_comb begin
    cnt_terminal = READ_LAST;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    if (state == DRAIN) begin
      cnt_terminal = DRAIN_LAST;
    end
    if (accept_start || ((state == READ) && at_terminal)) begin
      cnt_clear = 1'b1;
    end else if ((state == READ) || (state == DRAIN)) begin
      cnt_inc = 1'b1;
    end
  end

  fc_seq_counter #(
    .WIDTH(CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .inc        (cnt_inc),
    .terminal   (cnt_terminal),
    .count      (count),
    .at_terminal(at_terminal)
  );

  // State transitions plus registered outputs for the state being entered;
  // strobes default low so every one-cycle pulse clears itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      enable_read_current     <= 1'b0;
      wm_enable_read          <= 1'b0;
      wm_addr_sel             <= 1'b0;
      wm_address_read_current <= '0;
      bias_sel                <= 1'b0;
      fc_output_ready         <= 1'b0;
      enable_write_next       <= 1'b0;
      end_to_previous         <= 1'b0;
      start_to_next           <= 1'b0;
      busy                    <= 1'b0;
    end else begin
      enable_read_current     <= 1'b0;
      wm_enable_read          <= 1'b0;
      wm_addr_sel             <= 1'b0;
      wm_address_read_current <= '0;
      bias_sel                <= 1'b0;
      fc_output_ready         <= 1'b0;
      enable_write_next       <= 1'b0;
      end_to_previous         <= 1'b0;
      start_to_next           <= 1'b0;
      busy                    <= 1'b1;
      case (state)
        IDLE: begin
          if (start_from_previous) begin
            state               <= READ;
            enable_read_current <= 1'b1;
            wm_enable_read      <= 1'b1;
            wm_addr_sel         <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        READ: begin
          wm_addr_sel <= 1'b1;
          if (at_terminal) begin
            state <= DRAIN;
          end else begin
            enable_read_current     <= 1'b1;
            wm_enable_read          <= 1'b1;
            wm_address_read_current <= ADDR_W'(count_plus_one);
            end_to_previous         <= (count_plus_one == READ_LAST);
          end
        end
        DRAIN: begin
          wm_addr_sel <= 1'b1;
          if (at_terminal) begin
            state    <= BIAS;
            bias_sel <= 1'b1;
          end
        end
        BIAS: begin
          state             <= LATCH;
          fc_output_ready   <= 1'b1;
          enable_write_next <= 1'b1;
        end
        LATCH: begin
          state         <= HANDOFF;
          start_to_next <= 1'b1;
        end
        HANDOFF: begin
          state <= WAIT_NEXT;
        end
        WAIT_NEXT: begin
          if (end_from_next) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FC_SEQ_PERF_EN
  // Busy-cycle counter: restarts with each accepted run, holds in IDLE and
  // saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset || accept_start) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Testbench for fc_layer_sequencer: an FC1 instance (120 in, latency 3) and an
// FC2 instance (84 in, latency 1) share inputs and are compared every cycle
// against a timeline model built from elapsed cycles since a start.
module tb_fc_layer_sequencer;

  localparam int DEPTH0 = 120;
  localparam int LAT0   = 3;
  localparam int DEPTH1 = 84;
  localparam int LAT1   = 1;

  logic clk;
  logic reset;
  logic start_from_previous;
  logic end_from_next;

  logic       erc  [2];
  logic       wer  [2];
  logic       sel  [2];
  logic [6:0] addr [2];
  logic       bias [2];
  logic       fcr  [2];
  logic       ewn  [2];
  logic       etp  [2];
  logic       stn  [2];
  logic       busy [2];
`ifdef FC_SEQ_PERF_EN
  logic [31:0] perf [2];
`endif

  int n_checks;
  int n_pass;
  int cyc;
  int last_stn [2];

  // Model: run 0 = idle, 1 = running with t cycles elapsed, 2 = waiting.
  int          m_run  [2];
  int          m_t    [2];
  logic [31:0] m_perf [2];

  fc_layer_sequencer u_fc1 (
    .clk                    (clk),
    .reset                  (reset),
    .start_from_previous    (start_from_previous),
    .end_from_next          (end_from_next),
    .enable_read_current    (erc[0]),
    .wm_enable_read         (wer[0]),
    .wm_addr_sel            (sel[0]),
    .wm_address_read_current(addr[0]),
    .bias_sel               (bias[0]),
    .fc_output_ready        (fcr[0]),
    .enable_write_next      (ewn[0]),
    .end_to_previous        (etp[0]),
    .start_to_next          (stn[0]),
    .busy                   (busy[0])
`ifdef FC_SEQ_PERF_EN
    ,
    .perf_cycles            (perf[0])
`endif
  );

  fc_layer_sequencer #(
    .IFM_DEPTH  (DEPTH1),
    .MAC_LATENCY(LAT1)
  ) u_fc2 (
    .clk                    (clk),
    .reset                  (reset),
    .start_from_previous    (start_from_previous),
    .end_from_next          (end_from_next),
    .enable_read_current    (erc[1]),
    .wm_enable_read         (wer[1]),
    .wm_addr_sel            (sel[1]),
    .wm_address_read_current(addr[1]),
    .bias_sel               (bias[1]),
    .fc_output_ready        (fcr[1]),
    .enable_write_next      (ewn[1]),
    .end_to_previous        (etp[1]),
    .start_to_next          (stn[1]),
    .busy                   (busy[1])
`ifdef FC_SEQ_PERF_EN
    ,
    .perf_cycles            (perf[1])
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      $display("[TB] FAIL %s got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic e);
    reset               = r;
    start_from_previous = s;
    end_from_next       = e;
  endtask

  // Expected output vector from the elapsed-cycle timeline of one run.
  // Fields: erc wer sel addr[6:0] bias fcr ewn etp stn busy
  function automatic logic [15:0] modelVec(input int run, input int t, input int n, input int l);
    logic [15:0] v;
    v = '0;
    if (run == 2) begin
      v[0] = 1'b1;
    end else if (run == 1) begin
      v[0] = 1'b1;
      if (t < n) begin
        v[15]   = 1'b1;
        v[14]   = 1'b1;
        v[13]   = 1'b1;
        v[12:6] = 7'(t);
        v[2]    = (t == n - 1);
      end else if (t < n + l) begin
        v[13] = 1'b1;
      end else if (t == n + l) begin
        v[13] = 1'b1;
        v[5]  = 1'b1;
      end else if (t == n + l + 1) begin
        v[4] = 1'b1;
        v[3] = 1'b1;
      end else begin
        v[1] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic [15:0] obsVec(input int i);
    return {erc[i], wer[i], sel[i], addr[i], bias[i], fcr[i], ewn[i], etp[i], stn[i], busy[i]};
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then
  // compare both instances just after the edge.
  task automatic step();
    int n;
    int l;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      n = (i == 0) ? DEPTH0 : DEPTH1;
      l = (i == 0) ? LAT0 : LAT1;
      if (reset) begin
        m_run[i]  = 0;
        m_t[i]    = 0;
        m_perf[i] = '0;
      end else begin
        if (m_run[i] == 0 && start_from_previous) m_perf[i] = '0;
        else if (m_run[i] != 0 && m_perf[i] != 32'hFFFF_FFFF) m_perf[i] = m_perf[i] + 32'd1;
        case (m_run[i])
          0: if (start_from_previous) begin m_run[i] = 1; m_t[i] = 0; end
          1: if (m_t[i] == n + l + 2) m_run[i] = 2; else m_t[i] = m_t[i] + 1;
          default: if (end_from_next) m_run[i] = 0;
        endcase
      end
    end
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      n = (i == 0) ? DEPTH0 : DEPTH1;
      l = (i == 0) ? LAT0 : LAT1;
      checkOutput((i == 0) ? "fc1_outputs" : "fc2_outputs",
                  {16'h0, obsVec(i)}, {16'h0, modelVec(m_run[i], m_t[i], n, l)});
`ifdef FC_SEQ_PERF_EN
      checkOutput((i == 0) ? "fc1_perf" : "fc2_perf", perf[i], m_perf[i]);
`endif
      if (stn[i]) last_stn[i] = cyc;
    end
  endtask

  initial begin
    int t0;
    int ce;
    int k;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_t[i] = 0; m_perf[i] = '0; last_stn[i] = -1;
    end

    // Reset state.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();

    // Single start pulse: latency and perf count with end 10 cycles after handoff.
    last_stn[0] = -1; last_stn[1] = -1;
    t0 = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    k = 0;
    while (last_stn[0] < 0 && k < 400) begin step(); k++; end
    checkOutput("fc1_latency", last_stn[0] - t0, DEPTH0 + LAT0 + 3);
    checkOutput("fc2_latency", last_stn[1] - t0, DEPTH1 + LAT1 + 3);
    repeat (10) step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fc1_back_idle", {31'b0, busy[0]}, 32'd0);
`ifdef FC_SEQ_PERF_EN
    checkOutput("fc1_perf_total", perf[0], 32'd136);
    repeat (3) step();
    checkOutput("fc1_perf_hold", perf[0], 32'd136);
`endif

    // Start held high through a run; end 5 cycles after handoff; restart 1 cycle after IDLE.
    last_stn[0] = -1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    k = 0;
    while (last_stn[0] < 0 && k < 400) begin step(); k++; end
    checkOutput("fc1_hold_run_done", {31'b0, (last_stn[0] >= 0)}, 32'd1);
    repeat (5) step();
    applyStimulus(1'b0, 1'b1, 1'b1);
    ce = cyc;
    step();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("fc1_idle_after_end", {31'b0, busy[0]}, 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fc1_restart_gap", cyc - ce, 32'd2);
    checkOutput("fc1_restart_addr", {24'b0, erc[0], addr[0]}, {24'b0, 1'b1, 7'd0});

    // Stray start during READ and stray end during DRAIN are ignored.
    last_stn[0] = -1;
    k = 0;
    while (!(erc[0] && addr[0] == 7'd50) && k < 200) begin step(); k++; end
    applyStimulus(1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    k = 0;
    while (!etp[0] && k < 200) begin step(); k++; end
    checkOutput("fc1_end_to_prev_addr", {25'b0, addr[0]}, 32'd119);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    k = 0;
    while (last_stn[0] < 0 && k < 200) begin step(); k++; end
    repeat (5) step();
    checkOutput("fc1_wait_next_hold", {30'b0, busy[0], erc[0]}, {30'b0, 2'b10});
    applyStimulus(1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) step();

    // Reset at read address 60 aborts; a fresh start begins at address 0.
    applyStimulus(1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    k = 0;
    while (!(erc[0] && addr[0] == 7'd60) && k < 200) begin step(); k++; end
    applyStimulus(1'b1, 1'b0, 1'b0);
    step();
    checkOutput("fc1_reset_abort", {16'h0, obsVec(0)}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fc1_fresh_start", {24'b0, erc[0], addr[0]}, {24'b0, 1'b1, 7'd0});

    // Randomised traffic, including occasional resets.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
- Parameterised control unit that sequences one fully-connected layer datapath (weight memories, MAC array, bias add, output registers) in the LeNet-5 pipeline.
- Accepts a start from the previous layer and streams IFM_DEPTH input words with matching weight-memory read addresses.
- Drains the MAC pipeline, applies bias, latches outputs, then hands off to the next layer and waits for its completion.
- Replaces per-layer hand-written CUs; one instance is used for FC1 (120 in) and one for FC2 (84 in).

Parameters:
- IFM_DEPTH, 120, number of input activations per inference (≥2).
- ADDR_W, $clog2(IFM_DEPTH), width of the weight-memory read address.
- MAC_LATENCY, 3, datapath cycles from the last weight read to a valid accumulator (≥1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start_from_previous  in  1  previous layer has data ready; level or pulse; sampled only in IDLE.
- end_from_next  in  1  next layer has consumed outputs; sampled only in WAIT_NEXT.
- enable_read_current  out  1  read strobe to the previous layer's output buffer.
- wm_enable_read  out  1  weight/bias memory read enable.
- wm_addr_sel  out  1  1 = sequencer owns the memory address; 0 = RISC-V loader owns it.
- wm_address_read_current  out  ADDR_W  weight read address.
- bias_sel  out  1  selects the bias operand into the adder.
- fc_output_ready  out  1  one-cycle load strobe for the output registers.
- enable_write_next  out  1  write strobe into the next layer's input buffer.
- end_to_previous  out  1  one-cycle pulse: all inputs consumed.
- start_to_next  out  1  one-cycle pulse: outputs valid.
- busy  out  1  high in any state except IDLE.

Behaviour:
Reset:
- FSM goes to IDLE and the counter clears to 0.
- All outputs are 0, including wm_addr_sel (loader owns memory).
- Reset asserted in any state aborts the inference at the next edge; no end/start pulses are emitted.

States:
- IDLE:
  - All outputs 0.
  - start_from_previous=1 → READ, counter=0.
- READ:
  - wm_addr_sel=1, wm_enable_read=1, enable_read_current=1.
  - wm_address_read_current = counter.
  - Counter increments each cycle.
  - When counter==IFM_DEPTH-1: pulse end_to_previous in that same cycle and go to DRAIN with counter=0.
  - Duration is exactly IFM_DEPTH cycles.
- DRAIN:
  - wm_addr_sel=1; all other strobes 0.
  - Lasts MAC_LATENCY cycles, counted with the same counter.
  - Then → BIAS.
- BIAS:
  - bias_sel=1, wm_addr_sel=1, one cycle.
  - → LATCH.
- LATCH:
  - fc_output_ready=1, enable_write_next=1, one cycle.
  - → HANDOFF.
- HANDOFF:
  - start_to_next=1, one cycle.
  - → WAIT_NEXT.
- WAIT_NEXT:
  - All strobes 0, busy=1.
  - end_from_next=1 → IDLE.

Latency:
- start_from_previous accepted → start_to_next = IFM_DEPTH + MAC_LATENCY + 3 cycles.

Boundary rules:
- start_from_previous outside IDLE is ignored; it is not queued.
- start_from_previous on the same cycle WAIT_NEXT→IDLE is not accepted. It is accepted the following cycle if still high.
- end_from_next outside WAIT_NEXT is ignored.
- The counter never exceeds IFM_DEPTH-1, so addresses are always in range with no wrap.
- All outputs are registered (Moore); no combinational path from input to output.

Optional Feature:
- Macro: FC_SEQ_PERF_EN.
- Defined:
  - Adds output perf_cycles [31:0].
  - Counts clk cycles while busy=1.
  - Cleared to 0 on reset and on each IDLE→READ transition.
  - Holds its value in IDLE; saturates at 32'hFFFF_FFFF.
- Undefined:
  - The port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package lenet_ctrl_pkg:
  - State enum (IDLE, READ, DRAIN, BIAS, LATCH, HANDOFF, WAIT_NEXT).
  - Constants FC1_IFM_DEPTH=120, FC2_IFM_DEPTH=84, DEFAULT_MAC_LATENCY=3.
- One sub-module, fc_seq_counter:
  - Loadable up-counter with terminal-count flag, shared by READ and DRAIN.
- FSM and output registers stay in the top module.

Test Plan:
- Reset, then pulse start_from_previous with IFM_DEPTH=120, MAC_LATENCY=3:
  - Addresses run 0..119 on 120 consecutive cycles.
  - end_to_previous fires with address 119.
  - bias_sel fires 4 cycles later, then fc_output_ready/enable_write_next, then start_to_next 126 cycles after acceptance.
- Hold start_from_previous high through a whole run, with end_from_next asserted 5 cycles after start_to_next:
  - Returns to IDLE.
  - The second inference starts exactly 1 cycle later.
- Pulse start_from_previous during READ (cycle 50) and end_from_next during DRAIN:
  - No effect; address sequence is unchanged.
  - FSM still waits in WAIT_NEXT.
- Assert reset at READ address 60:
  - Next cycle all outputs are 0 and busy=0.
  - No end_to_previous pulse.
  - A fresh start restarts from address 0.
- Parameter variant IFM_DEPTH=84, MAC_LATENCY=1:
  - ADDR_W=7, addresses 0..83.
  - start_to_next 88 cycles after acceptance.
- With FC_SEQ_PERF_EN defined, end_from_next 10 cycles after start_to_next:
  - perf_cycles = 126+10 = 136 on return to IDLE, then holds.
